// File: rtl/div_unit_pkg.sv
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared encodings for the iterative divider and its execute-side users.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic C_DIV_RESULT_READY     = 1'b1;
  localparam logic C_DIV_RESULT_NOT_READY = 1'b0;
  localparam logic C_DIV_START            = 1'b1;
  localparam logic C_DIV_STOP             = 1'b0;

  // ALU operation codes that execute decodes into a divider request
  localparam logic [7:0] C_EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] C_EXE_DIVU_OP = 8'b0001_1011;

endpackage : div_unit_pkg

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle restoring divider (signed/unsigned), result {rem, quo}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

  localparam logic [CW-1:0] C_LAST = CW'(DW);

  div_state_e      r_state;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_dvd;       // dividend bits shift out, quotient bits shift in
  logic [DW-1:0]   r_dvs;
  logic [DW-1:0]   r_rem;
  logic            r_signed;
  logic            r_neg1;
  logic            r_neg2;
  logic [2*DW-1:0] r_result;
  logic            r_ready;

  div_state_e      w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [DW-1:0]   w_dvd_nxt;
  logic [DW-1:0]   w_dvs_nxt;
  logic [DW-1:0]   w_rem_nxt;
  logic            w_signed_nxt;
  logic            w_neg1_nxt;
  logic            w_neg2_nxt;
  logic [2*DW-1:0] w_result_nxt;
  logic            w_ready_nxt;

  logic [DW:0]     w_shift;
  logic [DW:0]     w_diff;
  logic [DW-1:0]   w_abs1;
  logic [DW-1:0]   w_abs2;
  logic [DW-1:0]   w_quo_fix;
  logic [DW-1:0]   w_rem_fix;

  // Magnitude of the most-negative value wraps to 2^(DW-1), which is correct read as unsigned
  assign w_abs1 = (signed_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;

  assign w_shift   = {r_rem, r_dvd[DW-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_quo_fix = (r_signed && (r_neg1 ^ r_neg2)) ? -r_dvd : r_dvd;
  assign w_rem_fix = (r_signed && r_neg1) ? -r_rem : r_rem;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dvd_nxt    = r_dvd;
    w_dvs_nxt    = r_dvs;
    w_rem_nxt    = r_rem;
    w_signed_nxt = r_signed;
    w_neg1_nxt   = r_neg1;
    w_neg2_nxt   = r_neg2;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;

    if (annul_i && (r_state != DIV_FREE)) begin
      w_state_nxt  = DIV_FREE;
      w_ready_nxt  = C_DIV_RESULT_NOT_READY;
      w_result_nxt = '0;
    end else begin
      unique case (r_state)
        DIV_FREE: begin
          w_ready_nxt  = C_DIV_RESULT_NOT_READY;
          w_result_nxt = '0;
          if ((start_i == C_DIV_START) && !annul_i) begin
            if (opdata2_i == '0) begin
              w_state_nxt = DIV_BYZERO;
            end else begin
              w_state_nxt  = DIV_ON;
              w_dvd_nxt    = w_abs1;
              w_dvs_nxt    = w_abs2;
              w_rem_nxt    = '0;
              w_cnt_nxt    = '0;
              w_signed_nxt = signed_i;
              w_neg1_nxt   = opdata1_i[DW-1];
              w_neg2_nxt   = opdata2_i[DW-1];
            end
          end
        end
        DIV_BYZERO: begin
          w_state_nxt  = DIV_END;
          w_result_nxt = '0;
          w_ready_nxt  = C_DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (r_cnt == C_LAST) begin
            w_state_nxt  = DIV_END;
            w_result_nxt = {w_rem_fix, w_quo_fix};
            w_ready_nxt  = C_DIV_RESULT_READY;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (!w_diff[DW]) begin
              w_rem_nxt = w_diff[DW-1:0];
              w_dvd_nxt = {r_dvd[DW-2:0], 1'b1};
            end else begin
              w_rem_nxt = w_shift[DW-1:0];
              w_dvd_nxt = {r_dvd[DW-2:0], 1'b0};
            end
          end
        end
        DIV_END: begin
          if (start_i == C_DIV_STOP) begin
            w_state_nxt  = DIV_FREE;
            w_ready_nxt  = C_DIV_RESULT_NOT_READY;
            w_result_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = DIV_FREE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= DIV_FREE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_signed <= 1'b0;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      r_result <= '0;
      r_ready  <= C_DIV_RESULT_NOT_READY;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dvs    <= w_dvs_nxt;
      r_rem    <= w_rem_nxt;
      r_signed <= w_signed_nxt;
      r_neg1   <= w_neg1_nxt;
      r_neg2   <= w_neg2_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule : div_unit

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module      : tb_div_unit
// Description : Scoreboard bench for div_unit at DW=32 and DW=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        s32, start32, annul32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        rdy32;
  logic        s8, start8, annul8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        rdy8;

  div_unit #(.DW(32)) u_dut32 (
    .clk(clk), .rst(rst), .signed_i(s32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(rdy32)
  );

  div_unit #(.DW(8)) u_dut8 (
    .clk(clk), .rst(rst), .signed_i(s8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(rdy8)
  );

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t m32, m8;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic p32 = 1'b0;
  logic p8 = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of ready must match the oldest outstanding request
  always @(negedge clk) begin
    if (rdy32 === 1'b1 && !p32) begin
      if (q32.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut32_unexpected_ready: got ready=1 expected ready=0");
      end else begin
        m32 = q32.pop_front();
        chk("dut32_result", res32, m32.res);
        chk("dut32_latency", 64'(cyc - m32.acc), 64'(m32.lat));
      end
    end
    p32 = (rdy32 === 1'b1);
    if (rdy8 === 1'b1 && !p8) begin
      if (q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut8_unexpected_ready: got ready=1 expected ready=0");
      end else begin
        m8 = q8.pop_front();
        chk("dut8_result", {48'b0, res8}, m8.res);
        chk("dut8_latency", 64'(cyc - m8.acc), 64'(m8.lat));
      end
    end
    p8 = (rdy8 === 1'b1);
  end

  function automatic logic cur_rdy(input bit w8);
    return w8 ? rdy8 : rdy32;
  endfunction

  function automatic logic [63:0] cur_res(input bit w8);
    return w8 ? {48'b0, res8} : res32;
  endfunction

  // Issue one request, hold start through completion, then release and check the clear
  task automatic op(input bit w8, input bit sg, input logic [31:0] a, input logic [31:0] b,
                    input logic [63:0] exp, input int lat, input string nm);
    exp_t e;
    int   k;
    @(negedge clk);
    e.res = exp; e.lat = lat; e.acc = cyc;
    if (w8) begin
      s8 = sg; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; q8.push_back(e);
    end else begin
      s32 = sg; a32 = a; b32 = b; start32 = 1'b1; q32.push_back(e);
    end
    @(negedge clk);
    if (w8) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~sg;
    end else begin
      a32 = $urandom; b32 = $urandom; s32 = ~sg;
    end
    k = 0;
    while (cur_rdy(w8) !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got ready=0 expected ready=1 within 100 cycles", nm);
    end else begin
      repeat (2) begin
        @(negedge clk);
        chk({nm, "_hold_ready"}, {63'b0, cur_rdy(w8)}, 64'd1);
        chk({nm, "_hold_result"}, cur_res(w8), exp);
      end
    end
    if (w8) start8 = 1'b0; else start32 = 1'b0;
    @(negedge clk);
    chk({nm, "_drop_ready"}, {63'b0, cur_rdy(w8)}, 64'd0);
    chk({nm, "_drop_result"}, cur_res(w8), 64'd0);
  endtask

  initial begin
    exp_t e;
    int   k;
    rst = 1'b0;
    s32 = 1'b0; start32 = 1'b0; annul32 = 1'b0; a32 = '0; b32 = '0;
    s8 = 1'b0; start8 = 1'b0; annul8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready32", {63'b0, rdy32}, 64'd0);
    chk("reset_result32", res32, 64'd0);
    chk("reset_ready8", {63'b0, rdy8}, 64'd0);
    chk("reset_result8", {48'b0, res8}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    op(0, 0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, "u100_7");
    op(0, 1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, "s_m7_2");
    op(0, 1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 34, "s_7_m2");
    op(0, 0, 32'd5, 32'd0, 64'd0, 2, "u_div0");
    op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34, "s_ovf");
    op(0, 1, 32'h8000_0000, 32'd2, {32'h0, 32'hC000_0000}, 34, "s_min_2");
    op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 34, "u_big");
    op(0, 0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 34, "u_max_1");

    // Annul at the 10th ON cycle: nothing may be presented
    @(negedge clk);
    s32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(negedge clk);
    repeat (9) @(negedge clk);
    annul32 = 1'b1; start32 = 1'b0;
    @(negedge clk);
    annul32 = 1'b0;
    chk("annul_ready", {63'b0, rdy32}, 64'd0);
    chk("annul_result", res32, 64'd0);
    repeat (40) @(negedge clk);
    chk("annul_no_ready", {63'b0, rdy32}, 64'd0);
    op(0, 0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, "after_annul");

    // Reset pulsed mid-ON
    @(negedge clk);
    s32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0; start32 = 1'b0;
    #1;
    chk("rst_on_ready", {63'b0, rdy32}, 64'd0);
    chk("rst_on_result", res32, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_on_no_ready", {63'b0, rdy32}, 64'd0);

    // Reset while a finished result is being presented clears it without a clock edge
    @(negedge clk);
    e.res = {32'd2, 32'd14}; e.lat = 34; e.acc = cyc;
    q32.push_back(e);
    s32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    k = 0;
    while (rdy32 !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      checks++; failures++;
      $display("FAIL rst_end_timeout: got ready=0 expected ready=1 within 100 cycles");
    end
    #2 rst = 1'b0;
    #1;
    chk("rst_end_ready", {63'b0, rdy32}, 64'd0);
    chk("rst_end_result", res32, 64'd0);
    @(negedge clk);
    start32 = 1'b0; rst = 1'b1;
    @(negedge clk);
    op(0, 0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, "after_rst");

    op(1, 0, 32'd200, 32'd3, 64'h0242, 10, "w8_u200_3");
    op(1, 1, 32'h80, 32'hFF, 64'h0080, 10, "w8_s_ovf");
    op(1, 1, 32'h80, 32'h02, 64'h00C0, 10, "w8_s_min_2");
    op(1, 0, 32'hFF, 32'h10, 64'h0F0F, 10, "w8_uff_10");
    op(1, 0, 32'h05, 32'h00, 64'h0000, 2, "w8_div0");

    repeat (3) @(negedge clk);
    chk("pending32", 64'(q32.size()), 64'd0);
    chk("pending8", 64'(q8.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_div_unit

`default_nettype wire
